// File: rtl/clk_gen_ds_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gen_ds_ctrl
// Sequences a select change into a clock generator and its downsampler.
// Both blocks are held in reset, the new select is applied, and then the
// resets are released in order with a settle wait after each release.
// A downsampler whose control nibble is zero is left parked in reset.
//
// Ports
//   clk_i        free-running controller reference clock
//   reset_i      synchronous active-high reset
//   v_i          configuration request valid
//   select_i     requested select: [3:0] generator tap, [7:4] downsample ctl
//   force_i      run the full sequence even if select_i matches select_o
//   ready_o      idle and able to accept a request
//   clk_reset_o  clock generator reset
//   ds_reset_o   downsampler reset
//   select_o     select driven into the clock block
//   done_o       one-cycle pulse when a sequence completes
//   busy_o       inverse of ready_o
// ---------------------------------------------------------------------------
module clk_gen_ds_ctrl #(
  parameter int unsigned reset_cycles_p = 4,
  parameter int unsigned cg_settle_p    = 8,
  parameter int unsigned ds_settle_p    = 16,
  parameter logic [7:0]  init_select_p  = 8'h00
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       v_i,
  input  logic [7:0] select_i,
  input  logic       force_i,
  output logic       ready_o,
  output logic       clk_reset_o,
  output logic       ds_reset_o,
  output logic [7:0] select_o,
  output logic       done_o,
  output logic       busy_o
);

  localparam int unsigned CntW = 8;

  // Wait-counter load values (N-1) for each timed state.
  localparam logic [CntW-1:0] AssertLoad = CntW'(reset_cycles_p - 1);
  localparam logic [CntW-1:0] CgLoad     = CntW'(cg_settle_p - 1);
  localparam logic [CntW-1:0] DsLoad     = CntW'(ds_settle_p - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ASSERT = 3'd1,
    S_APPLY  = 3'd2,
    S_REL_CG = 3'd3,
    S_REL_DS = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      pend_sel_q;
  logic [7:0]      select_q;
  logic            clk_reset_q;
  logic            ds_reset_q;
  logic            done_q;
  logic            ready_q;
  logic            busy_q;

  // Sequencer: every output is a flop updated together with the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_REL_CG;
      cnt_q       <= CgLoad;
      pend_sel_q  <= init_select_p;
      select_q    <= init_select_p;
      clk_reset_q <= 1'b1;
      ds_reset_q  <= 1'b1;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (v_i) begin
            pend_sel_q <= select_i;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            if (!force_i && (select_i == select_q)) begin
              // Nothing to change: report completion without touching resets.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_ASSERT;
              cnt_q       <= AssertLoad;
              clk_reset_q <= 1'b1;
              ds_reset_q  <= 1'b1;
            end
          end
        end

        S_ASSERT: begin
          if (cnt_q == '0) begin
            state_q  <= S_APPLY;
            select_q <= pend_sel_q;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        S_APPLY: begin
          state_q     <= S_REL_CG;
          cnt_q       <= CgLoad;
          clk_reset_q <= 1'b0;
        end

        S_REL_CG: begin
          if (clk_reset_q) begin
            // Only reachable straight out of reset_i: this edge is the real
            // entry into the generator settle wait.
            clk_reset_q <= 1'b0;
            cnt_q       <= CgLoad;
          end else if (cnt_q == '0) begin
            if (select_q[7:4] != 4'd0) begin
              state_q    <= S_REL_DS;
              cnt_q      <= DsLoad;
              ds_reset_q <= 1'b0;
            end else begin
              // Downsampler unused: leave it parked in reset.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        S_REL_DS: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign clk_reset_o = clk_reset_q;
  assign ds_reset_o  = ds_reset_q;
  assign select_o    = select_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_clk_gen_ds_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_gen_ds_ctrl
// Directed timing table, hand-written corner sequences (boot, busy drop,
// reset mid-sequence) and a randomized run against a timeline model.
// ---------------------------------------------------------------------------
module tb_clk_gen_ds_ctrl;

  localparam int unsigned RST_CYC = 4;
  localparam int unsigned CG      = 8;
  localparam int unsigned DS      = 16;
  localparam logic [7:0]  INIT    = 8'h03;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       v_i;
  logic [7:0] select_i;
  logic       force_i;
  logic       ready_o;
  logic       clk_reset_o;
  logic       ds_reset_o;
  logic [7:0] select_o;
  logic       done_o;
  logic       busy_o;

  always #5 clk = ~clk;

  clk_gen_ds_ctrl #(
    .reset_cycles_p(RST_CYC),
    .cg_settle_p   (CG),
    .ds_settle_p   (DS),
    .init_select_p (INIT)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .select_i   (select_i),
    .force_i    (force_i),
    .ready_o    (ready_o),
    .clk_reset_o(clk_reset_o),
    .ds_reset_o (ds_reset_o),
    .select_o   (select_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) until the controller reports ready.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    chk(name, 32'(ready_o), 32'd1);
  endtask

  // Called in boot cycle 0 (first edge with reset_i low already taken).
  task automatic check_boot(input string name);
    int crlow, dshi, done_c;
    logic rdy9;
    crlow = 0; dshi = 0; done_c = -1; rdy9 = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) tick();
      if (c <= 7 && !clk_reset_o) crlow++;
      if (ds_reset_o) dshi++;
      if (done_o && done_c < 0) done_c = c;
      if (c == 9) rdy9 = ready_o;
    end
    chk({name, "_cr_low_0to7"}, 32'(crlow), 32'd8);
    chk({name, "_ds_high"},     32'(dshi),  32'd10);
    chk({name, "_done_cyc"},    32'(done_c), 32'd8);
    chk({name, "_ready9"},      32'(rdy9),  32'd1);
    chk({name, "_select"},      32'(select_o), 32'(INIT));
  endtask

  // Issues one request from an idle cycle (cycle 0) and measures its timeline.
  task automatic run_req(input logic [7:0] s, input logic f,
                         output int done_c, output int sel_c,
                         output int crhi, output int dslow, output logic rdy_after);
    done_c = -1; sel_c = -1; crhi = 0; dslow = 0; rdy_after = 1'b0;
    v_i = 1'b1; select_i = s; force_i = f;
    if (select_o == s) sel_c = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      v_i = 1'b0;
      if (sel_c < 0 && select_o == s) sel_c = c;
      if (clk_reset_o) crhi++;
      if (dslow == 0 && !ds_reset_o) dslow = c;
      if (done_o && done_c < 0) done_c = c;
      else if (done_c >= 0) begin
        rdy_after = ready_o;
        break;
      end
    end
  endtask

  // Timeline model: one entry per future cycle of expected outputs.
  typedef struct packed {
    logic       ready;
    logic       cr;
    logic       dr;
    logic [7:0] sel;
    logic       done;
  } exp_t;

  exp_t cur;
  exp_t q[$];

  function automatic exp_t mk(input logic r, input logic c, input logic d,
                              input logic [7:0] s, input logic dn);
    exp_t e;
    e.ready = r; e.cr = c; e.dr = d; e.sel = s; e.done = dn;
    return e;
  endfunction

  // Generator settle, optional downsampler settle, then the done cycle.
  function automatic void push_tail(input logic [7:0] s);
    for (int i = 0; i < int'(CG); i++) q.push_back(mk(1'b0, 1'b0, 1'b1, s, 1'b0));
    if (s[7:4] != 4'd0)
      for (int i = 0; i < int'(DS); i++) q.push_back(mk(1'b0, 1'b0, 1'b0, s, 1'b0));
    q.push_back(mk(1'b0, 1'b0, (s[7:4] == 4'd0), s, 1'b1));
  endfunction

  typedef struct {
    logic [7:0] sel;
    logic       frc;
    int         done_cyc;
    int         sel_cyc;
    int         crhi_cnt;
    int         dslow_cyc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int   d_c, s_c, ch, dl, n_late, done_c;
    logic ra, r31;
    logic rr, rv, rf, acc;
    logic [7:0] rs;

    tbl[0] = '{8'h25, 1'b0, 30, 5, 5, 14};
    tbl[1] = '{8'h25, 1'b0,  1, 0, 0,  1};
    tbl[2] = '{8'h25, 1'b1, 30, 0, 5, 14};
    tbl[3] = '{8'h07, 1'b0, 14, 5, 5,  0};
    tbl[4] = '{8'h07, 1'b0,  1, 0, 0,  0};
    tbl[5] = '{8'h00, 1'b1, 14, 5, 5,  0};
    tbl[6] = '{8'hF1, 1'b0, 30, 5, 5, 14};

    reset_i = 1'b1; v_i = 1'b0; select_i = 8'h00; force_i = 1'b0;
    tick(); tick(); tick();

    // Reset values.
    chk("rst_ready",  32'(ready_o),     32'd0);
    chk("rst_busy",   32'(busy_o),      32'd1);
    chk("rst_cr",     32'(clk_reset_o), 32'd1);
    chk("rst_dr",     32'(ds_reset_o),  32'd1);
    chk("rst_select", 32'(select_o),    32'(INIT));
    chk("rst_done",   32'(done_o),      32'd0);

    // Boot sequence.
    reset_i = 1'b0;
    tick();
    check_boot("boot");

    // Directed timing table.
    foreach (tbl[i]) begin
      wait_ready($sformatf("t%0d_idle", i));
      run_req(tbl[i].sel, tbl[i].frc, d_c, s_c, ch, dl, ra);
      chk($sformatf("t%0d_done_cyc", i),  32'(d_c), 32'(tbl[i].done_cyc));
      chk($sformatf("t%0d_sel_cyc", i),   32'(s_c), 32'(tbl[i].sel_cyc));
      chk($sformatf("t%0d_cr_hi_cnt", i), 32'(ch),  32'(tbl[i].crhi_cnt));
      chk($sformatf("t%0d_ds_low_cyc", i),32'(dl),  32'(tbl[i].dslow_cyc));
      chk($sformatf("t%0d_ready_after", i), 32'(ra), 32'd1);
    end

    // Busy drop: later requests, including one in the DONE cycle, are ignored.
    wait_ready("busy_idle");
    v_i = 1'b1; select_i = 8'h5A; force_i = 1'b0;
    n_late = 0; done_c = -1; r31 = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      tick();
      if (select_o > 8'h80 && select_o < 8'hA0) n_late++;
      if (done_o && done_c < 0) done_c = c;
      if (c == 31) r31 = ready_o;
      v_i = (c <= 30);
      select_i = 8'h80 + 8'(c);
      force_i = 1'b1;
    end
    v_i = 1'b0;
    tick();
    chk("busy_late_select", 32'(n_late), 32'd0);
    chk("busy_done_cyc",    32'(done_c), 32'd30);
    chk("busy_ready31",     32'(r31),    32'd1);
    chk("busy_ready32",     32'(ready_o), 32'd1);
    chk("busy_select",      32'(select_o), 32'h5A);

    // Reset pulse during the downsampler settle wait.
    wait_ready("midrst_idle");
    v_i = 1'b1; select_i = 8'h25; force_i = 1'b0;
    tick();
    v_i = 1'b0;
    for (int c = 2; c <= 20; c++) tick();
    chk("midrst_in_rel_ds", 32'({clk_reset_o, ds_reset_o}), 32'b00);
    reset_i = 1'b1;
    tick();
    chk("midrst_cr",     32'(clk_reset_o), 32'd1);
    chk("midrst_dr",     32'(ds_reset_o),  32'd1);
    chk("midrst_select", 32'(select_o),    32'(INIT));
    chk("midrst_done",   32'(done_o),      32'd0);
    chk("midrst_ready",  32'(ready_o),     32'd0);
    reset_i = 1'b0;
    tick();
    check_boot("reboot");

    // Randomized run against the timeline model.
    cur = mk(1'b0, 1'b1, 1'b1, INIT, 1'b0);
    for (int n = 0; n < 2000 && bad < 40; n++) begin
      rr = (n == 0) || ($urandom_range(0, 399) == 0);
      rv = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 3) == 0) ? cur.sel : 8'($urandom);
      if ($urandom_range(0, 2) == 0) rs[7:4] = 4'd0;
      rf = ($urandom_range(0, 3) == 0);
      reset_i = rr; v_i = rv; select_i = rs; force_i = rf;
      acc = !rr && rv && cur.ready;
      tick();
      if (rr) begin
        q.delete();
        cur = mk(1'b0, 1'b1, 1'b1, INIT, 1'b0);
        push_tail(INIT);
      end else if (acc) begin
        if (!rf && rs == cur.sel) begin
          q.push_back(mk(1'b0, cur.cr, cur.dr, cur.sel, 1'b1));
        end else begin
          for (int i = 0; i < int'(RST_CYC); i++) q.push_back(mk(1'b0, 1'b1, 1'b1, cur.sel, 1'b0));
          q.push_back(mk(1'b0, 1'b1, 1'b1, rs, 1'b0));
          push_tail(rs);
        end
        cur = q.pop_front();
      end else if (q.size() != 0) begin
        cur = q.pop_front();
      end else begin
        cur = mk(1'b1, cur.cr, cur.dr, cur.sel, 1'b0);
      end
      chk($sformatf("rand_cyc%0d", n),
          32'({busy_o, ready_o, clk_reset_o, ds_reset_o, select_o, done_o}),
          32'({~cur.ready, cur}));
    end
    reset_i = 1'b0; v_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/clk_gen_ds_ctrl.md
CLK_GEN_DS_CTRL -- requirements
Module: clk_gen_ds_ctrl

Interface
REQ-001 Parameter: reset_cycles_p, default 4, cycles both clock-block resets are held before a new select is applied; legal range 1..255.
REQ-002 Parameter: cg_settle_p, default 8, cycles waited after clock-generator reset release; legal range 1..255.
REQ-003 Parameter: ds_settle_p, default 16, cycles waited after downsampler reset release; legal range 1..255.
REQ-004 Parameter: init_select_p, default 8'h00, select value driven out of reset.
REQ-005 Port: clk_i, input, 1, single controller clock (free-running reference, not the generated clock).
REQ-006 Port: reset_i, input, 1, synchronous active-high reset.
REQ-007 Port: v_i, input, 1, configuration request valid.
REQ-008 Port: select_i, input, 8, requested select; [3:0] clock-generator tap, [7:4] downsample control.
REQ-009 Port: force_i, input, 1, run the full sequence even when select_i equals the current select.
REQ-010 Port: ready_o, output, 1, controller idle and able to accept a request.
REQ-011 Port: clk_reset_o, output, 1, drives the clock generator's reset.
REQ-012 Port: ds_reset_o, output, 1, drives the downsampler's reset.
REQ-013 Port: select_o, output, 8, drives the clock block's select.
REQ-014 Port: done_o, output, 1, one-cycle pulse when a sequence completes.
REQ-015 Port: busy_o, output, 1, equals the inverse of ready_o.

Function
REQ-016 Handshake: a request is accepted on a clk_i edge where v_i and ready_o are both 1; select_i and force_i are captured into a pending register on that edge.
REQ-017 v_i while ready_o is 0 is ignored, with no queuing.
REQ-018 FSM states: IDLE, ASSERT, APPLY, REL_CG, REL_DS, DONE.
REQ-019 IDLE: ready_o=1; resets and select_o hold their values.
REQ-020 Fast path: on acceptance with force_i=0 and select_i==select_o, the next state is DONE, and resets and select_o do not change.
REQ-021 Otherwise, the next state after acceptance is ASSERT.
REQ-022 ASSERT: clk_reset_o=1 and ds_reset_o=1 for exactly reset_cycles_p cycles; the next state is APPLY.
REQ-023 APPLY: one cycle; select_o loads the pending select at the entry edge; both resets stay 1; the next state is REL_CG.
REQ-024 REL_CG: clk_reset_o=0 for cg_settle_p cycles.
REQ-025 Leaving REL_CG: the next state is REL_DS if select_o[7:4]!=0, otherwise DONE.
REQ-026 REL_DS: ds_reset_o=0 for ds_settle_p cycles; the next state is DONE.
REQ-027 DS parking: when select_o[7:4]==0, ds_reset_o remains 1 through REL_CG, DONE and IDLE, keeping the unused downsampler parked.
REQ-028 DONE: done_o=1 for exactly one cycle; the next state is IDLE.
REQ-029 Clean outputs: all outputs are driven directly from flops, with no combinational path from v_i, select_i or force_i to any output except ready_o/busy_o, which depend on state only.
REQ-030 Wait counter: a single shared 8-bit down-counter is loaded with (N-1) on state entry, and the state exits when the counter is 0 in that state; no wrap occurs.
REQ-031 Back-to-back requests: a request presented in the DONE cycle is not accepted; the earliest acceptance is the first IDLE cycle.

Reset
REQ-032 Values during reset_i=1: state=REL_CG with the counter loaded to cg_settle_p-1; clk_reset_o=1; ds_reset_o=1; select_o=init_select_p; done_o=0; ready_o=0.
REQ-033 Boot sequence: starting the cycle after reset_i falls, the controller runs REL_CG, then REL_DS or DONE per REQ-025 using init_select_p, and pulses done_o.
REQ-034 Reset mid-sequence: reset_i asserted in any state aborts the sequence within one edge to the REQ-032 values, and the pending select is discarded.

Verification (reset_cycles_p=4, cg_settle_p=8, ds_settle_p=16, init_select_p=8'h03)
REQ-035 Boot: reset_i falls at cycle 0 -> clk_reset_o=0 in cycles 0..7; ds_reset_o=1 throughout; done_o=1 at cycle 8; ready_o=1 from cycle 9.
REQ-036 Full sequence, select_i=8'h25 accepted at cycle 0 ->
  - resets=1 in cycles 1..5;
  - select_o=8'h25 from cycle 5;
  - clk_reset_o=0 from cycle 6;
  - ds_reset_o=0 from cycle 14;
  - done_o=1 at cycle 30;
  - ready_o=1 at cycle 31.
REQ-037 DS skip, select_i=8'h07 accepted at cycle 0 -> ds_reset_o=1 throughout; done_o=1 at cycle 14.
REQ-038 Fast path, select_i equal to current with force_i=0 -> done_o=1 the next cycle; resets and select_o unchanged. The same request with force_i=1 -> the full REQ-036 timing.
REQ-039 Busy drop: v_i=1 with a different select every cycle during a sequence -> only the first request takes effect; select_o never shows the later values.
REQ-040 Reset mid-sequence: reset_i pulsed for 1 cycle during REL_DS -> next edge shows clk_reset_o=1, ds_reset_o=1, select_o=8'h03, done_o=0; the boot sequence then repeats per REQ-035.
